// File: rtl/wb_arbiter.sv
// Writeback arbiter: fixed-priority (LSU > MDU > ALU) selection of one result per cycle into a
// registered register-file write port, plus a pending-write scoreboard for long-latency destinations.
// Optional ALU starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic              mdu_valid_i,
  output logic              mdu_ready_o,
  input  logic [ADDR_W-1:0] mdu_rd_i,
  input  logic [DATA_W-1:0] mdu_data_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LSU,
    SRC_MDU,
    SRC_ALU
  } src_e;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_arbiter: STARVE_LIMIT must be at least 1");
  end

  src_e              grant;
  logic              lsu_ready;
  logic              mdu_ready;
  logic              alu_ready;
  logic              force_alu;
  logic [ADDR_W-1:0] xfer_rd;
  logic [DATA_W-1:0] xfer_data;

  logic              we_q,      we_d;
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

`ifdef WB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_alu = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts consecutive denied ALU cycles; the forced grant itself clears it.
  always_comb begin
    starve_d = starve_q;
    if (!alu_valid_i || (grant == SRC_ALU)) begin
      starve_d = '0;
    end else if (!alu_ready) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_alu = 1'b0;
`endif

  // Ready depends only on higher-priority valids, never on the source's own valid.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    lsu_ready = 1'b1;
    mdu_ready = !lsu_valid_i;
    alu_ready = !lsu_valid_i && !mdu_valid_i;
    if (force_alu) begin
      lsu_ready = 1'b0;
      mdu_ready = 1'b0;
      alu_ready = 1'b1;
    end

    grant = SRC_NONE;
    if (alu_valid_i && alu_ready && force_alu) begin
      grant = SRC_ALU;
    end else if (lsu_valid_i && lsu_ready) begin
      grant = SRC_LSU;
    end else if (mdu_valid_i && mdu_ready) begin
      grant = SRC_MDU;
    end else if (alu_valid_i && alu_ready) begin
      grant = SRC_ALU;
    end
  end

  always_comb begin
    xfer_rd   = '0;
    xfer_data = '0;
    unique case (grant)
      SRC_LSU: begin
        xfer_rd   = lsu_rd_i;
        xfer_data = lsu_data_i;
      end
      SRC_MDU: begin
        xfer_rd   = mdu_rd_i;
        xfer_data = mdu_data_i;
      end
      SRC_ALU: begin
        xfer_rd   = alu_rd_i;
        xfer_data = alu_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;

    // A transfer to x0 completes the handshake but produces no write.
    if ((grant != SRC_NONE) && (xfer_rd != '0)) begin
      we_d    = 1'b1;
      waddr_d = xfer_rd;
      wdata_d = xfer_data;
      if (grant != SRC_ALU) begin
        pending_d[xfer_rd] = 1'b0;
      end
    end

    // Applied after the clear so a newer producer of the same register keeps it pending.
    if (issue_valid_i && (issue_rd_i != '0)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the scoreboard is a flop array that must start clean, so it is reset like any control state.
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign lsu_ready_o = lsu_ready;
  assign mdu_ready_o = mdu_ready;
  assign alu_ready_o = alu_ready;

  assign hazard1_o = (raddr1_i != '0) && pending_q[raddr1_i];
  assign hazard2_o = (raddr2_i != '0) && pending_q[raddr2_i];

  assign reg_we_o    = we_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random traffic, all checked
// against a priority-list / scoreboard-array reference model. Honours WB_STARVE_GUARD_EN.
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  localparam int S_LSU  = 0;
  localparam int S_MDU  = 1;
  localparam int S_ALU  = 2;
  localparam int S_NONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v[3];
  logic [AW-1:0] rd[3];
  logic [DW-1:0] dat[3];
  logic          issue_v;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] ra1, ra2;

  logic          lsu_ready_o, mdu_ready_o, alu_ready_o;
  logic          hazard1_o, hazard2_o;
  logic          reg_we_o;
  logic [AW-1:0] reg_waddr_o;
  logic [DW-1:0] reg_wdata_o;

  // Reference model state
  bit            pend[2**AW];
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_known;
  int            starve;

  int checks = 0;
  int errors = 0;
  bit keep_lsu = 1'b0;
  int last_gnt = S_NONE;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid_i  (v[S_ALU]),
    .alu_ready_o  (alu_ready_o),
    .alu_rd_i     (rd[S_ALU]),
    .alu_data_i   (dat[S_ALU]),
    .lsu_valid_i  (v[S_LSU]),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (rd[S_LSU]),
    .lsu_data_i   (dat[S_LSU]),
    .mdu_valid_i  (v[S_MDU]),
    .mdu_ready_o  (mdu_ready_o),
    .mdu_rd_i     (rd[S_MDU]),
    .mdu_data_i   (dat[S_MDU]),
    .issue_valid_i(issue_v),
    .issue_rd_i   (issue_rd),
    .raddr1_i     (ra1),
    .raddr2_i     (ra2),
    .hazard1_o    (hazard1_o),
    .hazard2_o    (hazard2_o),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1'b1;
    starve  = 0;
  endtask

  function automatic bit starve_force();
`ifdef WB_STARVE_GUARD_EN
    return starve == LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_hazard(input logic [AW-1:0] a);
    return (a != '0) && pend[a];
  endfunction

  // One clock: check combinational outputs before the edge, advance the model, check registers after.
  task automatic cycle();
    int ord[3];
    bit ahead;
    bit exp_rdy[3];
    int gnt;
    @(negedge clk);
    #1;
    if (starve_force()) ord = '{S_ALU, S_LSU, S_MDU};
    else                ord = '{S_LSU, S_MDU, S_ALU};
    ahead = 1'b0;
    gnt   = S_NONE;
    for (int i = 0; i < 3; i++) begin
      exp_rdy[ord[i]] = !ahead;
      if (v[ord[i]] && !ahead) gnt = ord[i];
      ahead = ahead | v[ord[i]];
    end
    check("lsu_ready", 32'(lsu_ready_o), 32'(exp_rdy[S_LSU]));
    check("mdu_ready", 32'(mdu_ready_o), 32'(exp_rdy[S_MDU]));
    check("alu_ready", 32'(alu_ready_o), 32'(exp_rdy[S_ALU]));
    check("hazard1_pre", 32'(hazard1_o), 32'(exp_hazard(ra1)));
    check("hazard2_pre", 32'(hazard2_o), 32'(exp_hazard(ra2)));

    @(posedge clk);
    m_we = 1'b0;
    if (gnt != S_NONE) begin
      if (rd[gnt] != '0) begin
        m_we    = 1'b1;
        m_addr  = rd[gnt];
        m_data  = dat[gnt];
        m_known = 1'b1;
        if (gnt != S_ALU) pend[rd[gnt]] = 1'b0;
      end else begin
        m_known = 1'b0;
      end
    end
    if (issue_v && issue_rd != '0) pend[issue_rd] = 1'b1;
    if (v[S_ALU] && gnt != S_ALU) starve++;
    else                          starve = 0;
    last_gnt = gnt;

    #1;
    check("reg_we", 32'(reg_we_o), 32'(m_we));
    if (m_known) begin
      check("reg_waddr", 32'(reg_waddr_o), 32'(m_addr));
      check("reg_wdata", reg_wdata_o, m_data);
    end
    check("hazard1_post", 32'(hazard1_o), 32'(exp_hazard(ra1)));
    check("hazard2_post", 32'(hazard2_o), 32'(exp_hazard(ra2)));

    if (gnt != S_NONE && !(gnt == S_LSU && keep_lsu)) v[gnt] = 1'b0;
    issue_v = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] r, input logic [DW-1:0] d);
    v[s]   = 1'b1;
    rd[s]  = r;
    dat[s] = d;
  endtask

  initial begin
    int alu_gnt_at;
    int exp_gnt_at;
    logic [AW-1:0] seq_addr[3];

    for (int s = 0; s < 3; s++) begin
      v[s]   = 1'b0;
      rd[s]  = '0;
      dat[s] = '0;
    end
    issue_v  = 1'b0;
    issue_rd = '0;
    ra1      = '0;
    ra2      = '0;
    model_reset();

    // Reset state
    #1;
    check("rst_we", 32'(reg_we_o), 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_hazard1", 32'(hazard1_o), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Simultaneous valids: LSU, then MDU, then ALU
    set_src(S_LSU, 5'd5, 32'hA5A5_0005);
    set_src(S_MDU, 5'd6, 32'hA5A5_0006);
    set_src(S_ALU, 5'd7, 32'hA5A5_0007);
    for (int i = 0; i < 3; i++) begin
      cycle();
      seq_addr[i] = reg_waddr_o;
    end
    check("prio_first", 32'(seq_addr[0]), 32'd5);
    check("prio_second", 32'(seq_addr[1]), 32'd6);
    check("prio_third", 32'(seq_addr[2]), 32'd7);

    // Scoreboard set, hazard, clear by LSU writeback
    issue_v  = 1'b1;
    issue_rd = 5'd9;
    cycle();
    ra1 = 5'd9;
    cycle();
    check("sb_hazard_set", 32'(hazard1_o), 32'd1);
    set_src(S_LSU, 5'd9, 32'h0000_DEAD);
    cycle();
    check("sb_hazard_clear", 32'(hazard1_o), 32'd0);
    check("sb_wdata", reg_wdata_o, 32'h0000_DEAD);

    // Same-cycle issue and MDU clear of rd=4: set wins
    issue_v  = 1'b1;
    issue_rd = 5'd4;
    cycle();
    issue_v  = 1'b1;
    issue_rd = 5'd4;
    ra2      = 5'd4;
    set_src(S_MDU, 5'd4, 32'h1234_5678);
    cycle();
    check("set_wins_hazard2", 32'(hazard2_o), 32'd1);

    // x0 destination: handshake completes, no write, no scoreboard effect
    set_src(S_ALU, 5'd0, 32'hFFFF_FFFF);
    cycle();
    check("rd0_no_write", 32'(reg_we_o), 32'd0);
    issue_v  = 1'b1;
    issue_rd = 5'd0;
    ra1      = 5'd0;
    cycle();
    check("rd0_no_hazard", 32'(hazard1_o), 32'd0);

    // Reset while a write is on the port
    set_src(S_ALU, 5'd12, 32'h0000_0055);
    issue_v  = 1'b1;
    issue_rd = 5'd13;
    ra1      = 5'd13;
    cycle();
    check("pre_reset_we", 32'(reg_we_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(reg_we_o), 32'd0);
    check("midrst_waddr", 32'(reg_waddr_o), 32'd0);
    check("midrst_wdata", reg_wdata_o, 32'd0);
    check("midrst_hazard1", 32'(hazard1_o), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_src(S_ALU, 5'd3, 32'h0000_0011);
    cycle();
    check("postrst_we", 32'(reg_we_o), 32'd1);
    check("postrst_waddr", 32'(reg_waddr_o), 32'd3);
    check("postrst_wdata", reg_wdata_o, 32'h0000_0011);

    // Starvation: LSU valid every cycle alongside a waiting ALU result
    keep_lsu   = 1'b1;
    alu_gnt_at = -1;
    set_src(S_LSU, 5'd20, 32'hC0DE_0020);
    set_src(S_ALU, 5'd21, 32'hC0DE_0021);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (last_gnt == S_ALU && alu_gnt_at < 0) alu_gnt_at = k;
    end
`ifdef WB_STARVE_GUARD_EN
    exp_gnt_at = LIMIT + 1;
`else
    exp_gnt_at = -1;
`endif
    check("starve_grant_cycle", 32'(alu_gnt_at), 32'(exp_gnt_at));
    keep_lsu  = 1'b0;
    v[S_LSU]  = 1'b0;
    cycle();

    // Random traffic; sources hold their item until it is accepted
    for (int n = 0; n < 400; n++) begin
      if (!v[S_LSU] && $urandom_range(0, 2) == 0) set_src(S_LSU, AW'($urandom_range(0, 7)), $urandom);
      if (!v[S_MDU] && $urandom_range(0, 1) == 0) set_src(S_MDU, AW'($urandom_range(0, 7)), $urandom);
      if (!v[S_ALU] && $urandom_range(0, 1) == 0) set_src(S_ALU, AW'($urandom_range(0, 7)), $urandom);
      issue_v  = 1'($urandom_range(0, 1));
      issue_rd = AW'($urandom_range(0, 7));
      ra1      = AW'($urandom_range(0, 7));
      ra2      = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
